// File: rtl/vga_box_renderer_if.sv
// Colour-config handshake for vga_box_renderer: one write carries both box and background colour.
interface vga_box_renderer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_box_rgb;
  logic [23:0] cfg_bg_rgb;

  modport master (output cfg_valid, output cfg_box_rgb, output cfg_bg_rgb, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_box_rgb, input cfg_bg_rgb, output cfg_ready);
endinterface

// File: rtl/vga_box_renderer.sv
// Bouncing-box pixel colour stage behind a VGA timing generator; colours commit at frame end.
// Optional screen-edge white border enabled by defining VGA_BOX_BORDER_EN.
module vga_box_renderer #(
  parameter int unsigned BOX_W = 32,
  parameter int unsigned BOX_H = 32,
  parameter int unsigned STEP  = 2,
  parameter int unsigned H_VIS = 640,
  parameter int unsigned V_VIS = 480
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                vga_clk_i,
  input  logic [9:0]          hpix_i,
  input  logic [9:0]          vpix_i,
  input  logic                frame_end_i,
  input  logic                pause_i,
  vga_box_renderer_if.slave   cfg,
  output logic [7:0]          red_o,
  output logic [7:0]          green_o,
  output logic [7:0]          blue_o,
  output logic                box_hit_o
);

  localparam logic [10:0] XMax  = 11'(H_VIS - BOX_W);
  localparam logic [10:0] YMax  = 11'(V_VIS - BOX_H);
  localparam logic [10:0] StepW = 11'(STEP);
  localparam logic [10:0] BoxW  = 11'(BOX_W);
  localparam logic [10:0] BoxH  = 11'(BOX_H);

  localparam logic [0:0] CfgIdle = 1'b0;
  localparam logic [0:0] CfgPend = 1'b1;

  logic        frame_end_q;
  logic        frame_tick;
  logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dx_q, dx_d, dy_q, dy_d;  // 1 = moving in the + direction
  logic [0:0]  cfg_st_q, cfg_st_d;
  logic [23:0] box_rgb_q, box_rgb_d, bg_rgb_q, bg_rgb_d;
  logic [23:0] sh_box_q, sh_box_d, sh_bg_q, sh_bg_d;
  logic        vis, in_box, vis_q, in_box_q;
  logic [10:0] hx, vy;
  logic [23:0] rgb_d, rgb_q;
  logic        hit_q;

  assign frame_tick = frame_end_i & ~frame_end_q;
  assign cfg.cfg_ready = (cfg_st_q == CfgIdle);

  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    if (frame_tick && !pause_i) begin
      if (dx_q) begin
        if (box_x_q + StepW >= XMax) begin
          box_x_d = XMax;
          dx_d    = 1'b0;
        end else begin
          box_x_d = box_x_q + StepW;
        end
      end else if (box_x_q <= StepW) begin
        box_x_d = '0;
        dx_d    = 1'b1;
      end else begin
        box_x_d = box_x_q - StepW;
      end
      if (dy_q) begin
        if (box_y_q + StepW >= YMax) begin
          box_y_d = YMax;
          dy_d    = 1'b0;
        end else begin
          box_y_d = box_y_q + StepW;
        end
      end else if (box_y_q <= StepW) begin
        box_y_d = '0;
        dy_d    = 1'b1;
      end else begin
        box_y_d = box_y_q - StepW;
      end
    end
  end

  // An accept in IDLE never commits in the same cycle; the commit waits for the next tick.
  always_comb begin
    cfg_st_d  = cfg_st_q;
    sh_box_d  = sh_box_q;
    sh_bg_d   = sh_bg_q;
    box_rgb_d = box_rgb_q;
    bg_rgb_d  = bg_rgb_q;
    if (cfg_st_q == CfgIdle) begin
      if (cfg.cfg_valid) begin
        sh_box_d = cfg.cfg_box_rgb;
        sh_bg_d  = cfg.cfg_bg_rgb;
        cfg_st_d = CfgPend;
      end
    end else if (frame_tick) begin
      box_rgb_d = sh_box_q;
      bg_rgb_d  = sh_bg_q;
      cfg_st_d  = CfgIdle;
    end
  end

  always_comb begin
    hx     = {1'b0, hpix_i};
    vy     = {1'b0, vpix_i};
    vis    = (hpix_i != 10'h3FF) && (vpix_i != 10'h3FF);
    in_box = vis && (hx >= box_x_q) && (hx <= box_x_q + BoxW - 11'd1)
                 && (vy >= box_y_q) && (vy <= box_y_q + BoxH - 11'd1);
  end

`ifdef VGA_BOX_BORDER_EN
  logic border, border_q;

  assign border = vis && ((hpix_i == 10'd0) || (hpix_i == 10'(H_VIS - 1)) ||
                          (vpix_i == 10'd0) || (vpix_i == 10'(V_VIS - 1)));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      border_q <= 1'b0;
    end else if (vga_clk_i) begin
      border_q <= border;
    end
  end

  always_comb begin
    rgb_d = '0;
    if (border_q)      rgb_d = 24'hFFFFFF;
    else if (in_box_q) rgb_d = box_rgb_q;
    else if (vis_q)    rgb_d = bg_rgb_q;
  end
`else
  always_comb begin
    rgb_d = '0;
    if (in_box_q)   rgb_d = box_rgb_q;
    else if (vis_q) rgb_d = bg_rgb_q;
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_end_q <= 1'b0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      cfg_st_q    <= CfgIdle;
      box_rgb_q   <= 24'hFF0000;
      bg_rgb_q    <= 24'h000000;
      sh_box_q    <= '0;
      sh_bg_q     <= '0;
      vis_q       <= 1'b0;
      in_box_q    <= 1'b0;
      rgb_q       <= '0;
      hit_q       <= 1'b0;
    end else begin
      frame_end_q <= frame_end_i;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      cfg_st_q    <= cfg_st_d;
      box_rgb_q   <= box_rgb_d;
      bg_rgb_q    <= bg_rgb_d;
      sh_box_q    <= sh_box_d;
      sh_bg_q     <= sh_bg_d;
      if (vga_clk_i) begin
        vis_q    <= vis;
        in_box_q <= in_box;
        rgb_q    <= rgb_d;
        hit_q    <= in_box_q;
      end
    end
  end

  assign red_o     = rgb_q[23:16];
  assign green_o   = rgb_q[15:8];
  assign blue_o    = rgb_q[7:0];
  assign box_hit_o = hit_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed bench for vga_box_renderer: reset image, motion/bounce, colour commit, pause, reset.
module tb_vga_box_renderer;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       vga_clk = 1'b0;
  logic [9:0] hpix = 10'h3FF;
  logic [9:0] vpix = 10'h3FF;
  logic       frame_end = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] red, green, blue;
  logic       box_hit;
  int         total = 0;
  int         bad = 0;
  logic [23:0] rgb;
  logic        hit;

  vga_box_renderer_if cfg_if ();

  vga_box_renderer dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .vga_clk_i   (vga_clk),
    .hpix_i      (hpix),
    .vpix_i      (vpix),
    .frame_end_i (frame_end),
    .pause_i     (pause),
    .cfg         (cfg_if),
    .red_o       (red),
    .green_o     (green),
    .blue_o      (blue),
    .box_hit_o   (box_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Two strobes push the coordinate through both stages; sample on the falling edge.
  task automatic probe(input int x, input int y);
    @(negedge clk);
    hpix = 10'(x);
    vpix = 10'(y);
    vga_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vga_clk = 1'b0;
    hpix = 10'h3FF;
    vpix = 10'h3FF;
    rgb = {red, green, blue};
    hit = box_hit;
  endtask

  task automatic pchk(input string tag, input int x, input int y,
                      input logic [23:0] exp_rgb, input logic exp_hit);
    probe(x, y);
    chk({tag, ".rgb"}, {8'h0, rgb}, {8'h0, exp_rgb});
    chk({tag, ".hit"}, {31'h0, hit}, {31'h0, exp_hit});
  endtask

  task automatic tick(input int width);
    @(negedge clk);
    frame_end = 1'b1;
    repeat (width) @(negedge clk);
    frame_end = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [23:0] box_c, input logic [23:0] bg_c);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_box_rgb = box_c;
    cfg_if.cfg_bg_rgb = bg_c;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_box_rgb = '0;
    cfg_if.cfg_bg_rgb = '0;
    repeat (3) @(negedge clk);
    chk("rst.rgb", {8'h0, red, green, blue}, 32'h0);
    chk("rst.hit", {31'h0, box_hit}, 32'h0);
    chk("rst.ready", {31'h0, cfg_if.cfg_ready}, 32'h1);
    n_rst = 1'b1;

    // Reset image: red box at (0,0) over black.
    pchk("t1.origin", 0, 0, 24'hFF0000, 1'b1);
    pchk("t1.corner", 31, 31, 24'hFF0000, 1'b1);
    pchk("t1.right", 32, 0, 24'h000000, 1'b0);
    pchk("t1.below", 0, 32, 24'h000000, 1'b0);
    pchk("t1.bg", 100, 200, 24'h000000, 1'b0);
    pchk("t1.hblank", 10'h3FF, 5, 24'h000000, 1'b0);
    pchk("t1.vblank", 5, 10'h3FF, 24'h000000, 1'b0);

    // Five 3-clock-wide frame_end pulses move the box 5 x 2 = 10.
    repeat (5) tick(3);
    pchk("t2.tl", 10, 10, 24'hFF0000, 1'b1);
    pchk("t2.left", 9, 10, 24'h000000, 1'b0);
    pchk("t2.br", 41, 41, 24'hFF0000, 1'b1);
    pchk("t2.pastr", 42, 41, 24'h000000, 1'b0);

    // 298 more ticks: x=606; y bounced at 448 after tick 224, then 79 ticks down to 290.
    repeat (298) tick(1);
    pchk("t3.x606", 606, 290, 24'hFF0000, 1'b1);
    pchk("t3.x605", 605, 290, 24'h000000, 1'b0);
    tick(1);
    pchk("t3.x608", 608, 288, 24'hFF0000, 1'b1);
    pchk("t3.x607", 607, 288, 24'h000000, 1'b0);
    pchk("t3.edge", 639, 319, 24'hFF0000, 1'b1);
    tick(1);
    pchk("t3.back606", 606, 286, 24'hFF0000, 1'b1);
    pchk("t3.back638", 638, 286, 24'h000000, 1'b0);
    // 303 ticks: x 606->0 (flip +); y 286->0 in 143 ticks (flip +), then up to 320.
    repeat (303) tick(1);
    pchk("t3.x0", 0, 320, 24'hFF0000, 1'b1);
    pchk("t3.x0r", 32, 320, 24'h000000, 1'b0);
    pchk("t3.x0up", 0, 319, 24'h000000, 1'b0);
    tick(1);
    pchk("t3.x2", 2, 322, 24'hFF0000, 1'b1);
    pchk("t3.x2l", 1, 322, 24'h000000, 1'b0);

    // Colour config: held pending until the next frame tick.
    cfg_write(24'h00FF00, 24'h0000FF);
    chk("t4.notready", {31'h0, cfg_if.cfg_ready}, 32'h0);
    pchk("t4.oldbox", 2, 322, 24'hFF0000, 1'b1);
    pchk("t4.oldbg", 100, 100, 24'h000000, 1'b0);
    tick(1);
    chk("t4.ready", {31'h0, cfg_if.cfg_ready}, 32'h1);
    pchk("t4.newbox", 4, 324, 24'h00FF00, 1'b1);
    pchk("t4.newbg", 100, 100, 24'h0000FF, 1'b0);

    // Pause: box frozen at (4,324), pending config still commits.
    pause = 1'b1;
    cfg_write(24'h123456, 24'hABCDEF);
    repeat (3) tick(1);
    chk("t5.ready", {31'h0, cfg_if.cfg_ready}, 32'h1);
    pchk("t5.box", 4, 324, 24'h123456, 1'b1);
    pchk("t5.bg", 3, 324, 24'hABCDEF, 1'b0);

    // Accept coinciding with a tick: no commit until the following tick.
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_box_rgb = 24'h0F0F0F;
    cfg_if.cfg_bg_rgb = 24'h010203;
    frame_end = 1'b1;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    frame_end = 1'b0;
    chk("t5.samepend", {31'h0, cfg_if.cfg_ready}, 32'h0);
    pchk("t5.samebox", 4, 324, 24'h123456, 1'b1);
    tick(1);
    pchk("t5.commit", 4, 324, 24'h0F0F0F, 1'b1);
    pchk("t5.commitbg", 3, 324, 24'h010203, 1'b0);

    // Unpause: direction was preserved (+,+).
    pause = 1'b0;
    tick(1);
    pchk("t5.resume", 6, 326, 24'h0F0F0F, 1'b1);
    pchk("t5.resumel", 5, 326, 24'h010203, 1'b0);

    // Asynchronous reset mid-line while the output is nonzero.
    probe(6, 326);
    chk("t6.pre", {8'h0, rgb}, 32'h000F0F0F);
    #2;
    n_rst = 1'b0;
    #1;
    chk("t6.rgb0", {8'h0, red, green, blue}, 32'h0);
    chk("t6.hit0", {31'h0, box_hit}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    pchk("t6.origin", 0, 0, 24'hFF0000, 1'b1);
    pchk("t6.bg", 32, 0, 24'h000000, 1'b0);
    pchk("t6.oldpos", 6, 326, 24'h000000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_box_renderer.md
Name: vga_box_renderer

Overview:
- Pixel colour stage directly downstream of the VGA timing generator.
- Consumes the timing generator's pixel coordinates, the pixel-rate strobe and the frame-end flag.
- Draws a solid box that moves and bounces inside the 640x480 visible area over a background colour, and produces 8-bit R/G/B for the video DAC.
- Box and background colours are loaded through a valid/ready config port and take effect only at a frame boundary, so a frame never mixes old and new colours.

Parameters:
- BOX_W, 32, box width in pixels (1..640)
- BOX_H, 32, box height in pixels (1..480)
- STEP, 2, pixels moved per axis per frame (1..BOX_W, and 1..BOX_H)
- H_VIS, 640, visible width
- V_VIS, 480, visible height

Ports:
- clk  in  1  system clock (vga_clk strobe is derived from it)
- n_rst  in  1  asynchronous active-low reset
- vga_clk  in  1  single-cycle pixel strobe; the pipeline advances only when it is 1
- hPix  in  10  pixel x; all-ones means non-visible
- vPix  in  10  pixel y; all-ones means non-visible
- frame_end  in  1  frame rollover flag; may stay high for several clk cycles
- pause  in  1  1 = hold the box position
- cfg_valid  in  1  a colour-config write is offered
- cfg_ready  out  1  the block can accept a config write
- cfg_box_rgb  in  24  box colour {R,G,B}
- cfg_bg_rgb  in  24  background colour {R,G,B}
- red  out  8  DAC red
- green  out  8  DAC green
- blue  out  8  DAC blue
- box_hit  out  1  registered; 1 when the current output pixel is inside the box

Behaviour:
Reset (async, n_rst=0):
- box_x=0, box_y=0, dx=+1, dy=+1.
- box colour = 24'hFF0000; bg colour = 24'h000000; shadow registers = 0.
- cfg state = IDLE, so cfg_ready=1.
- red/green/blue=0, box_hit=0, pipeline valid bits=0, frame_end edge register=0.

Frame tick:
- frame_tick = frame_end & ~frame_end_q, giving exactly one tick per frame.

Motion (on frame_tick, only when pause=0), per axis with limit X_MAX = H_VIS-BOX_W:
- Moving +: if box_x+STEP >= X_MAX then box_x=X_MAX and dx flips to -; else box_x += STEP.
- Moving -: if box_x <= STEP then box_x=0 and dx flips to +; else box_x -= STEP.
- The Y axis works the same way with Y_MAX = V_VIS-BOX_H.
- Arithmetic is 11-bit unsigned, so there is no wrap. A corner hit flips both directions on the same tick.
- pause=1 freezes both position and direction; colour commits still happen.

Config FSM:
- IDLE: cfg_ready=1. cfg_valid & cfg_ready latches both inputs into the shadow registers and moves to PENDING.
- PENDING: cfg_ready=0. On frame_tick, shadow is copied to the active colours and the FSM returns to IDLE.
- A frame_tick in the same cycle as the IDLE accept does not commit. The commit happens on the next tick.

Pixel pipeline (both stages advance only on vga_clk=1 cycles; registers hold otherwise):
- S1: vis = (hPix != 10'h3FF) && (vPix != 10'h3FF). in_box = vis && hPix in [box_x, box_x+BOX_W-1] && vPix in [box_y, box_y+BOX_H-1]. Register vis and in_box.
- S2: red/green/blue = in_box ? box colour : (vis ? bg colour : 0). box_hit = in_box.
- Latency: 2 vga_clk strobes from coordinate to RGB.
- Non-visible pixels always output 0.
- Position and colours are sampled live in S1. Updates happen only at frame_tick, which falls in blanking, so no mid-frame change is visible.

Reset mid-frame:
- Outputs go to 0 immediately.
- The next frame starts from the reset state.

Optional Feature:
Macro VGA_BOX_BORDER_EN.
- When defined: any visible pixel with hPix==0, hPix==H_VIS-1, vPix==0 or vPix==V_VIS-1 outputs 24'hFFFFFF. The border has priority over box and background and does not affect box_hit.
- When undefined: no border logic is present.

Test Plan:
1. Reset then hold frame_end=0: every visible pixel gives RGB=0x000000 except x,y in [0,31], which gives 0xFF0000. box_hit=1 only there. Non-visible pixels give 0.
2. Apply 5 frame_end pulses (each 3 clk wide) with pause=0: box_x=box_y=10. Each wide pulse moves the box exactly once.
3. Start at box_x=606, dx=+, one tick: box_x=608, dx becomes -. Next tick: box_x=606. Symmetric check at box_x=1 moving -: box_x=0, dx becomes +.
4. cfg_valid=1 with box=0x00FF00, bg=0x0000FF: cfg_ready drops the next cycle. Colours stay old until the next frame_tick, then a box pixel gives 0x00FF00 and a background pixel 0x0000FF. cfg_ready returns to 1.
5. pause=1 across 3 frame ticks: position and direction unchanged, and a pending colour config still commits.
6. Assert n_rst low mid-line while RGB is nonzero: RGB=0 asynchronously, and after release the box is at (0,0) with red colour.
